// File: rtl/blowfish_round_sequencer_pkg.sv
// ============================================================================
// Module : blowfish_round_sequencer_pkg
// Brief  : Shared constants, FSM encoding and subkey/S-box helpers for the
//          iterative Blowfish round sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package blowfish_round_sequencer_pkg;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Initial P-array (hex digits of pi), indexed 1..18.
    function automatic logic [31:0] pinit(input logic [4:0] i);
        logic [31:0] v;
        v = 32'h0;
        case (i)
            5'd1:    v = 32'h243f6a88;
            5'd2:    v = 32'h85a308d3;
            5'd3:    v = 32'h13198a2e;
            5'd4:    v = 32'h03707344;
            5'd5:    v = 32'ha4093822;
            5'd6:    v = 32'h299f31d0;
            5'd7:    v = 32'h082efa98;
            5'd8:    v = 32'hec4e6c89;
            5'd9:    v = 32'h452821e6;
            5'd10:   v = 32'h38d01377;
            5'd11:   v = 32'hbe5466cf;
            5'd12:   v = 32'h34e90c6c;
            5'd13:   v = 32'hc0ac29b7;
            5'd14:   v = 32'hc97c50dd;
            5'd15:   v = 32'h3f84d5b5;
            5'd16:   v = 32'hb5470917;
            5'd17:   v = 32'h9216d5d9;
            5'd18:   v = 32'h8979fb1b;
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    // P[i] = PINIT[i] ^ K[((i-1) mod 14) + 1]; K1 occupies key[447:416].
    function automatic logic [31:0] subkey(input logic [447:0] key, input logic [4:0] i);
        logic [3:0] k;
        logic [8:0] base;
        k    = (i > 5'd14) ? 4'(i - 5'd14) : i[3:0];
        base = {4'(4'd14 - k), 5'b00000};
        return pinit(i) ^ key[base +: 32];
    endfunction

    function automatic logic [4:0] subkey_index(input logic mode, input logic [4:0] j);
        return (mode == MODE_DEC) ? 5'(5'd19 - j) : j;
    endfunction

    function automatic logic [31:0] sbox_seed(input logic [1:0] box);
        logic [31:0] v;
        case (box)
            2'd0:    v = 32'hd1310ba6;
            2'd1:    v = 32'h98dfb5ac;
            2'd2:    v = 32'h2ffd72db;
            default: v = 32'hd01adfb7;
        endcase
        return v;
    endfunction

    // Fixed pseudo-random S-box fill; only ever evaluated at elaboration as ROM contents.
    function automatic logic [31:0] sbox_entry(input logic [1:0] box, input logic [7:0] x);
        logic [31:0] v;
        v = {x, ~x, x ^ 8'h5a, 8'(x + 8'h3c)} ^ sbox_seed(box);
        v = v * 32'h9e3779b1;
        v = v ^ (v >> 16);
        v = v * 32'h85ebca6b;
        v = v ^ (v >> 13);
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/blowfish_round_sequencer_feistal.sv
// ============================================================================
// Module : feistal
// Brief  : Combinational Blowfish F-function, ((S1[a]+S2[b])^S3[c])+S4[d].
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module feistal
    import blowfish_round_sequencer_pkg::*;
(
    input  logic [31:0] x,
    output logic [31:0] f
);

    logic [31:0] w_rom [4][256];
    logic [31:0] w_s1;
    logic [31:0] w_s2;
    logic [31:0] w_s3;
    logic [31:0] w_s4;

    generate
        for (genvar b = 0; b < 4; b++) begin : g_box
            for (genvar e = 0; e < 256; e++) begin : g_ent
                localparam logic [31:0] C_ENT = sbox_entry(2'(b), 8'(e));
                assign w_rom[b][e] = C_ENT;
            end
        end
    endgenerate

    assign w_s1 = w_rom[0][x[31:24]];
    assign w_s2 = w_rom[1][x[23:16]];
    assign w_s3 = w_rom[2][x[15:8]];
    assign w_s4 = w_rom[3][x[7:0]];
    assign f    = ((w_s1 + w_s2) ^ w_s3) + w_s4;

endmodule

`default_nettype wire

// File: rtl/blowfish_round_sequencer.sv
// ============================================================================
// Module : blowfish_round_sequencer
// Brief  : Iterative Blowfish encrypt/decrypt, one Feistel round per clock,
//          valid/ready on both sides.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module blowfish_round_sequencer
    import blowfish_round_sequencer_pkg::*;
#(
    parameter int ROUNDS = 16,
    parameter int KEY_W  = 448
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_mode,
    input  logic [63:0]                    in_data,
    input  logic [KEY_W-1:0]               in_key,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [63:0]                    out_data,
    output logic                           busy,
    output logic [$clog2(ROUNDS+1)-1:0]    round
);

    localparam int ROUND_W = $clog2(ROUNDS + 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [KEY_W-1:0]     r_key;
    logic                 r_mode;
    logic [31:0]          r_l;
    logic [31:0]          r_r;
    logic [63:0]          r_out;
    logic [ROUND_W-1:0]   r_round;

    logic [31:0]          w_f;
    logic [31:0]          w_mix;
    logic [31:0]          w_p_first;
    logic [31:0]          w_p_next;
    logic [31:0]          w_p_last;
    logic                 w_last;

    feistal u_feistal (
        .x (r_l),
        .f (w_f)
    );

    // First subkey comes straight from the input key because the key register
    // is only being loaded on the accept edge.
    assign w_p_first = subkey(in_key, subkey_index(in_mode, 5'd1));
    assign w_p_next  = subkey(r_key, subkey_index(r_mode, 5'(r_round + 1'b1)));
    assign w_p_last  = subkey(r_key, subkey_index(r_mode, 5'd18));
    assign w_mix     = r_r ^ w_f;
    assign w_last    = (r_round == ROUND_W'(ROUNDS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = ST_ROUND;
                end
            end
            ST_ROUND: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key   <= '0;
            r_mode  <= MODE_ENC;
            r_l     <= '0;
            r_r     <= '0;
            r_out   <= '0;
            r_round <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_key   <= in_key;
                        r_mode  <= in_mode;
                        r_l     <= in_data[63:32] ^ w_p_first;
                        r_r     <= in_data[31:0];
                        r_round <= ROUND_W'(1);
                    end
                end
                ST_ROUND: begin
                    if (!w_last) begin
                        r_l     <= w_p_next ^ w_mix;
                        r_r     <= r_l;
                        r_round <= r_round + 1'b1;
                    end else begin
                        // Final round: undo the swap and whiten with P17/P18.
                        r_out   <= {w_p_last ^ r_l, w_p_next ^ w_mix};
                        r_round <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_data = r_out;
    assign round    = r_round;

endmodule

`default_nettype wire

// File: tb/tb_blowfish_round_sequencer.sv
// ============================================================================
// Module : tb_blowfish_round_sequencer
// Brief  : Directed self-checking bench with a scoreboard and a reference
//          Blowfish model written in the classic swap-loop form.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_blowfish_round_sequencer;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_mode;
    logic [63:0]  in_data;
    logic [447:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic         busy;
    logic [4:0]   round;

    int           checks = 0;
    int           errors = 0;
    int           cyc    = 0;
    int           acc_cyc;
    logic [63:0]  exp_q [$];

    blowfish_round_sequencer #(.ROUNDS(16), .KEY_W(448)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .round     (round)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_sbox(input int box, input int x);
        logic [31:0] seeds [4];
        logic [7:0]  b8;
        logic [31:0] v;
        seeds = '{32'hd1310ba6, 32'h98dfb5ac, 32'h2ffd72db, 32'hd01adfb7};
        b8 = x[7:0];
        v  = {b8, ~b8, b8 ^ 8'h5a, 8'(b8 + 8'h3c)} ^ seeds[box];
        v  = v * 32'h9e3779b1;
        v  = v ^ (v >> 16);
        v  = v * 32'h85ebca6b;
        v  = v ^ (v >> 13);
        return v;
    endfunction

    function automatic logic [31:0] m_f(input logic [31:0] x);
        return ((m_sbox(0, int'(x[31:24])) + m_sbox(1, int'(x[23:16])))
                ^ m_sbox(2, int'(x[15:8]))) + m_sbox(3, int'(x[7:0]));
    endfunction

    function automatic logic [63:0] m_crypt(input logic [447:0] key, input logic mode,
                                            input logic [63:0] blk);
        logic [31:0] pi [18];
        logic [31:0] p  [18];
        logic [31:0] kw [14];
        logic [31:0] xl, xr, t;
        pi = '{32'h243f6a88, 32'h85a308d3, 32'h13198a2e, 32'h03707344, 32'ha4093822,
               32'h299f31d0, 32'h082efa98, 32'hec4e6c89, 32'h452821e6, 32'h38d01377,
               32'hbe5466cf, 32'h34e90c6c, 32'hc0ac29b7, 32'hc97c50dd, 32'h3f84d5b5,
               32'hb5470917, 32'h9216d5d9, 32'h8979fb1b};
        for (int n = 0; n < 14; n++) kw[n] = key[447 - 32*n -: 32];
        for (int i = 0; i < 18; i++) begin
            if (mode) p[i] = pi[17 - i] ^ kw[(17 - i) % 14];
            else      p[i] = pi[i] ^ kw[i % 14];
        end
        xl = blk[63:32];
        xr = blk[31:0];
        for (int i = 0; i < 16; i++) begin
            xl = xl ^ p[i];
            xr = xr ^ m_f(xl);
            t = xl; xl = xr; xr = t;
        end
        t = xl; xl = xr; xr = t;
        xr = xr ^ p[16];
        xl = xl ^ p[17];
        return {xl, xr};
    endfunction

    function automatic logic [447:0] rand_key();
        logic [447:0] k;
        for (int n = 0; n < 14; n++) k[32*n +: 32] = $urandom;
        return k;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_output: observed %h expected none", out_data);
            end
            if (exp_q.size() != 0) chk("result", out_data, exp_q.pop_front());
        end
    end

    task automatic send(input logic m, input logic [447:0] k, input logic [63:0] d,
                        input logic [63:0] exp);
        @(posedge clk); #1;
        in_valid = 1'b1; in_mode = m; in_key = k; in_data = d;
        exp_q.push_back(exp);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        chk("accept_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL drain_timeout: observed %0d pending expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [63:0]  c;
        logic [63:0]  ea, eb;
        logic [447:0] k, ka, kb;
        logic [63:0]  da, db;
        int           a1, a2, a3;

        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; in_key = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy",      {63'd0, busy},      64'd0);
        chk("rst_round",     {59'd0, round},     64'd0);
        chk("rst_out_data",  out_data,           64'd0);
        #1 rst = 1'b0;

        // Round trip encrypt with latency/busy/round profile.
        c = m_crypt('0, 1'b0, 64'h0123456789abcdef);
        send(1'b0, '0, 64'h0123456789abcdef, c);
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            chk("lat_busy",  {63'd0, busy},      (n <= 16) ? 64'd1 : 64'd0);
            chk("lat_round", {59'd0, round},     (n <= 16) ? 64'(n) : 64'd0);
            chk("lat_valid", {63'd0, out_valid}, (n == 17) ? 64'd1 : 64'd0);
        end
        send(1'b1, '0, c, 64'h0123456789abcdef);
        drain();

        // Backpressure with a second block waiting.
        ka = rand_key(); kb = rand_key();
        da = {$urandom, $urandom}; db = {$urandom, $urandom};
        ea = m_crypt(ka, 1'b0, da); eb = m_crypt(kb, 1'b1, db);
        @(posedge clk); #1 out_ready = 1'b0;
        send(1'b0, ka, da, ea);
        for (int i = 0; i < 30 && !out_valid; i++) @(negedge clk);
        chk("bp_valid", {63'd0, out_valid}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b1; in_mode = 1'b1; in_key = kb; in_data = db;
        exp_q.push_back(eb);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_data",  out_data,           ea);
            chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_in_ready",   {63'd0, in_ready},  64'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_second_busy",  {63'd0, busy},  64'd1);
        chk("bp_second_round", {59'd0, round}, 64'd1);
        drain();

        // Asynchronous reset at round 8 while the key input moves.
        k = rand_key();
        send(1'b0, k, {$urandom, $urandom}, 64'd0);
        for (int i = 0; i < 20 && round != 5'd8; i++) @(negedge clk);
        chk("mid_round8", {59'd0, round}, 64'd8);
        #1 rst = 1'b1; in_key = rand_key();
        void'(exp_q.pop_back());
        #1;
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_ready", {63'd0, in_ready},  64'd1);
        chk("mid_rst_round", {59'd0, round},     64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1 rst = 1'b0;
        send(1'b0, {448{1'b1}}, 64'hffffffff00000000,
             m_crypt({448{1'b1}}, 1'b0, 64'hffffffff00000000));
        drain();

        // Key and mode isolation during the rounds.
        k = rand_key(); da = {$urandom, $urandom};
        send(1'b1, k, da, m_crypt(k, 1'b1, da));
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            in_key = rand_key(); in_mode = ~in_mode; in_data = {$urandom, $urandom};
        end
        drain();

        // Back-to-back encrypt/decrypt/encrypt.
        k = rand_key(); da = {$urandom, $urandom};
        send(1'b0, k, da, m_crypt(k, 1'b0, da));
        a1 = acc_cyc;
        k = rand_key(); da = {$urandom, $urandom};
        send(1'b1, k, da, m_crypt(k, 1'b1, da));
        a2 = acc_cyc;
        k = rand_key(); da = {$urandom, $urandom};
        send(1'b0, k, da, m_crypt(k, 1'b0, da));
        a3 = acc_cyc;
        drain();
        chk("gap_1_2", 64'(a2 - a1), 64'd18);
        chk("gap_2_3", 64'(a3 - a2), 64'd18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
